// File: rtl/card_shoe.sv
// 52-card shoe: fills a deck, shuffles it with a Galois LFSR
// (Fisher-Yates by rejection) and deals cards on request.
module card_shoe #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req,
  input  logic       shuffle,
  output logic       card_valid,
  output logic [3:0] card_rank,
  output logic [1:0] card_suit,
  output logic [3:0] card_value,
  output logic [5:0] cards_left,
  output logic       ready,
  output logic       empty
);

  localparam logic [15:0] SEED_I = (SEED == 16'h0) ? 16'h0001 : SEED;
  localparam logic [15:0] MASK   = 16'hB400;

  typedef enum logic [1:0] {
    S_INIT,
    S_SHUF,
    S_READY
  } state_t;

  state_t      state_q;
  logic [15:0] lfsr_q, lfsr_d;
  logic [5:0]  k_q, i_q, p_q, left_q;
  logic [5:0]  deck_q [52];
  logic        valid_q, ready_q;
  logic [3:0]  rank_q, value_q;
  logic [1:0]  suit_q;

  logic [5:0]  j;
  logic        swap;
  logic [5:0]  cid, cidx;
  logic [1:0]  dsuit;
  logic [3:0]  drank, dvalue;

  assign lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? MASK : 16'h0);
  assign j      = lfsr_q[5:0];
  assign swap   = (state_q == S_SHUF) && (j <= i_q);

  // id -> (suit, rank) without a divider
  always_comb begin
    cid   = deck_q[p_q];
    dsuit = 2'd0;
    cidx  = cid;
    if (cid >= 6'd39) begin
      dsuit = 2'd3;
      cidx  = cid - 6'd39;
    end else if (cid >= 6'd26) begin
      dsuit = 2'd2;
      cidx  = cid - 6'd26;
    end else if (cid >= 6'd13) begin
      dsuit = 2'd1;
      cidx  = cid - 6'd13;
    end
    drank  = cidx[3:0] + 4'd1;
    dvalue = (drank > 4'd10) ? 4'd10 : drank;
  end

  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      deck_q[k_q] <= k_q;
    end else if (swap) begin
      deck_q[i_q] <= deck_q[j];
      deck_q[j]   <= deck_q[i_q];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_INIT;
      lfsr_q  <= SEED_I;
      k_q     <= 6'd0;
      i_q     <= 6'd0;
      p_q     <= 6'd0;
      left_q  <= 6'd0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      rank_q  <= 4'd0;
      suit_q  <= 2'd0;
      value_q <= 4'd0;
    end else begin
      lfsr_q  <= lfsr_d;
      valid_q <= 1'b0;
      if (shuffle) begin
        state_q <= S_INIT;
        k_q     <= 6'd0;
        ready_q <= 1'b0;
        left_q  <= 6'd0;
      end else begin
        unique case (state_q)
          S_INIT: begin
            k_q <= k_q + 6'd1;
            if (k_q == 6'd51) begin
              state_q <= S_SHUF;
              k_q     <= 6'd0;
              i_q     <= 6'd51;
              p_q     <= 6'd0;
            end
          end
          S_SHUF: begin
            if (swap) begin
              i_q <= i_q - 6'd1;
              if (i_q == 6'd1) begin
                state_q <= S_READY;
                ready_q <= 1'b1;
                left_q  <= 6'd52;
              end
            end
          end
          S_READY: begin
            if (req && left_q != 6'd0) begin
              valid_q <= 1'b1;
              rank_q  <= drank;
              suit_q  <= dsuit;
              value_q <= dvalue;
              p_q     <= p_q + 6'd1;
              left_q  <= left_q - 6'd1;
            end
          end
          default: state_q <= S_INIT;
        endcase
      end
    end
  end

  assign card_valid = valid_q;
  assign card_rank  = rank_q;
  assign card_suit  = suit_q;
  assign card_value = value_q;
  assign cards_left = left_q;
  assign ready      = ready_q;
  assign empty      = ready_q && (left_q == 6'd0);

endmodule

// File: tb/tb_card_shoe.sv
// Bench for card_shoe: shuffle model, full deals, reshuffle,
// empty / not-ready requests and mid-shuffle reset.
module tb_card_shoe;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       resetn, req, shuffle;
  logic       card_valid, ready, empty;
  logic [3:0] card_rank, card_value;
  logic [1:0] card_suit;
  logic [5:0] cards_left;

  card_shoe #(.SEED(SEED)) dut (
    .clk(clk), .resetn(resetn), .req(req), .shuffle(shuffle),
    .card_valid(card_valid), .card_rank(card_rank),
    .card_suit(card_suit), .card_value(card_value),
    .cards_left(cards_left), .ready(ready), .empty(empty)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int mdeck[52];
  int deck1[52];
  int seq1[52];
  int seq2[52];
  int seen[52];
  int mcyc, cyc1;
  int h_rank = 0, h_suit = 0, h_value = 0;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // free-running LFSR reference, to seed the model on a reshuffle
  always @(posedge clk or negedge resetn)
    if (!resetn) m_lfsr <= SEED;
    else m_lfsr <= lstep(m_lfsr);

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // l0: LFSR value in effect on the first fill cycle
  task automatic build(input logic [15:0] l0);
    logic [15:0] l;
    int i, jj, t;
    l = l0;
    for (int k = 0; k < 52; k++) mdeck[k] = k;
    for (int k = 0; k < 52; k++) l = lstep(l);
    mcyc = 52;
    i = 51;
    while (i >= 1 && mcyc < 100000) begin
      jj = int'(l[5:0]);
      if (jj <= i) begin
        t = mdeck[i];
        mdeck[i] = mdeck[jj];
        mdeck[jj] = t;
        i--;
      end
      l = lstep(l);
      mcyc++;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_card(input string tag, input int id, input int left);
    int r;
    r = id % 13 + 1;
    chk({tag, "_valid"}, int'(card_valid), 1);
    chk({tag, "_rank"}, int'(card_rank), r);
    chk({tag, "_suit"}, int'(card_suit), id / 13);
    chk({tag, "_value"}, int'(card_value), (r > 10) ? 10 : r);
    chk({tag, "_left"}, int'(cards_left), left);
    h_rank = r;
    h_suit = id / 13;
    h_value = (r > 10) ? 10 : r;
  endtask

  task automatic chk_hold(input string tag, input int left);
    chk({tag, "_valid"}, int'(card_valid), 0);
    chk({tag, "_rank"}, int'(card_rank), h_rank);
    chk({tag, "_suit"}, int'(card_suit), h_suit);
    chk({tag, "_value"}, int'(card_value), h_value);
    chk({tag, "_left"}, int'(cards_left), left);
  endtask

  task automatic deal_pulse(input string tag, input int id, input int left);
    req = 1'b1;
    tick();
    req = 1'b0;
    expect_card(tag, id, left);
  endtask

  // random req while not ready; checks no deal and held outputs
  task automatic wait_ready(input string tag, input int exp);
    int cnt;
    cnt = 0;
    while (!ready && cnt < 3000) begin
      req = 1'($urandom_range(0, 1));
      tick();
      cnt++;
      if (!ready) chk_hold({tag, "_wait"}, 0);
    end
    req = 1'b0;
    chk({tag, "_cycles"}, cnt, exp);
    chk({tag, "_min103"}, int'(cnt >= 103), 1);
    chk({tag, "_left52"}, int'(cards_left), 52);
    chk({tag, "_empty0"}, int'(empty), 0);
  endtask

  initial begin
    int nd;
    resetn = 1'b0;
    req = 1'b0;
    shuffle = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(card_valid), 0);
    chk("rst_rank", int'(card_rank), 0);
    chk("rst_suit", int'(card_suit), 0);
    chk("rst_value", int'(card_value), 0);
    chk("rst_left", int'(cards_left), 0);
    chk("rst_ready", int'(ready), 0);
    chk("rst_empty", int'(empty), 0);

    build(SEED);
    deck1 = mdeck;
    cyc1 = mcyc;
    resetn = 1'b1;
    wait_ready("boot", cyc1);

    foreach (seen[k]) seen[k] = 0;
    for (int n = 0; n < 52; n++) begin
      deal_pulse("d1", deck1[n], 51 - n);
      seq1[n] = int'(card_suit) * 13 + int'(card_rank) - 1;
      if (seq1[n] >= 0 && seq1[n] < 52) seen[seq1[n]]++;
      repeat ($urandom_range(0, 2)) begin
        tick();
        chk_hold("d1_gap", 51 - n);
      end
    end
    nd = 0;
    foreach (seen[k]) if (seen[k] == 1) nd++;
    chk("d1_unique", nd, 52);
    chk("d1_empty", int'(empty), 1);

    req = 1'b1;
    tick();
    req = 1'b0;
    chk_hold("req_empty", 0);
    chk("req_empty_e", int'(empty), 1);

    shuffle = 1'b1;
    tick();
    shuffle = 1'b0;
    chk("shuf_ready", int'(ready), 0);
    chk_hold("shuf", 0);
    build(m_lfsr);
    wait_ready("shuf2", mcyc);

    req = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      expect_card("burst", mdeck[n], 51 - n);
      seq2[n] = int'(card_suit) * 13 + int'(card_rank) - 1;
    end
    req = 1'b0;
    tick();
    chk_hold("burst_end", 47);
    for (int n = 5; n < 22; n++) begin
      deal_pulse("d2", mdeck[n], 51 - n);
      seq2[n] = int'(card_suit) * 13 + int'(card_rank) - 1;
    end
    nd = 0;
    for (int n = 0; n < 22; n++) if (seq2[n] != deck1[n]) nd++;
    chk("d2_differs", int'(nd > 0), 1);
    chk("d2_left30", int'(cards_left), 30);

    req = 1'b1;
    shuffle = 1'b1;
    tick();
    req = 1'b0;
    shuffle = 1'b0;
    chk("rs_ready", int'(ready), 0);
    chk_hold("rs", 0);

    repeat (60) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("ares_valid", int'(card_valid), 0);
    chk("ares_rank", int'(card_rank), 0);
    chk("ares_suit", int'(card_suit), 0);
    chk("ares_value", int'(card_value), 0);
    chk("ares_left", int'(cards_left), 0);
    chk("ares_ready", int'(ready), 0);
    chk("ares_empty", int'(empty), 0);
    @(negedge clk);
    h_rank = 0;
    h_suit = 0;
    h_value = 0;
    resetn = 1'b1;
    wait_ready("reboot", cyc1);

    req = 1'b1;
    for (int n = 0; n < 52; n++) begin
      tick();
      expect_card("d3", deck1[n], 51 - n);
    end
    req = 1'b0;
    tick();
    chk_hold("d3_end", 0);
    chk("d3_empty", int'(empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
